// File: rtl/instr_issue_ctrl.sv
// Register-scoreboard issue control: stalls decoded instructions on RAW/WAW hazards,
// in-flight limit or branch back-pressure, and strobes one execution branch per issue.
module instr_issue_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int N_BRANCHES   = 4,
    localparam int BW = (N_BRANCHES > 1) ? $clog2(N_BRANCHES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            src_a,
    input  logic [3:0]            src_b,
    input  logic [3:0]            src_c,
    input  logic                  src_a_reg,
    input  logic                  src_b_reg,
    input  logic                  src_c_reg,
    input  logic                  src_a_needed,
    input  logic                  src_b_needed,
    input  logic                  src_c_needed,
    input  logic [3:0]            dest,
    input  logic                  commits,
    input  logic [BW-1:0]         branch,
    input  logic [N_BRANCHES-1:0] branch_ready,
    output logic [N_BRANCHES-1:0] issue_valid,
    output logic [3:0]            issue_dest,
    input  logic                  commit_valid,
    input  logic [3:0]            commit_dest,
    input  logic                  flush,
    output logic [3:0]            inflight,
    output logic                  idle,
    output logic                  err_commit
);

    localparam int unsigned NB      = N_BRANCHES;
    localparam logic [3:0]  MAX_CNT = 4'(MAX_INFLIGHT);

    logic [15:0]           r_pending;
    logic [3:0]            r_inflight;
    logic [N_BRANCHES-1:0] r_issue_valid;
    logic [3:0]            r_issue_dest;
    logic                  r_err_commit;

    logic [N_BRANCHES-1:0] w_branch_oh;
    logic                  w_branch_ok;
    logic                  w_haz_a;
    logic                  w_haz_b;
    logic                  w_haz_c;
    logic                  w_haz_waw;
    logic                  w_full;
    logic                  w_ready;
    logic                  w_issue;
    logic                  w_inc;
    logic                  w_dec;
    logic [15:0]           w_set;
    logic [15:0]           w_clr;

    // Decoding through a loop keeps out-of-range branch codes from ever looking ready.
    always_comb begin
        w_branch_oh = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (32'(branch) == i) begin
                w_branch_oh[i] = 1'b1;
            end
        end
    end

    assign w_branch_ok = |(w_branch_oh & branch_ready);

    // Hazards look only at the registered scoreboard; a same-cycle commit does not bypass.
    assign w_haz_a   = src_a_needed & src_a_reg & r_pending[src_a];
    assign w_haz_b   = src_b_needed & src_b_reg & r_pending[src_b];
    assign w_haz_c   = src_c_needed & src_c_reg & r_pending[src_c];
    assign w_haz_waw = commits & r_pending[dest];
    assign w_full    = commits & (r_inflight == MAX_CNT);

    assign w_ready = ~reset & ~flush & w_branch_ok & ~w_haz_a & ~w_haz_b & ~w_haz_c
                     & ~w_haz_waw & ~w_full;
    assign w_issue = in_valid & w_ready;

    assign w_inc = w_issue & commits;
    assign w_dec = commit_valid & r_pending[commit_dest];
    assign w_set = w_inc ? (16'd1 << dest) : '0;
    assign w_clr = w_dec ? (16'd1 << commit_dest) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending     <= '0;
            r_inflight    <= '0;
            r_issue_valid <= '0;
            r_issue_dest  <= '0;
            r_err_commit  <= 1'b0;
        end else if (flush) begin
            r_pending     <= '0;
            r_inflight    <= '0;
            r_issue_valid <= '0;
        end else begin
            // WAW stalling guarantees the set and clear bits never coincide.
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_inc && !w_dec) begin
                r_inflight <= r_inflight + 4'd1;
            end else if (w_dec && !w_inc) begin
                r_inflight <= r_inflight - 4'd1;
            end
            if (commit_valid && !r_pending[commit_dest]) begin
                r_err_commit <= 1'b1;
            end
            r_issue_valid <= w_issue ? w_branch_oh : '0;
            if (w_issue) begin
                r_issue_dest <= dest;
            end
        end
    end

    assign in_ready    = w_ready;
    assign issue_valid = r_issue_valid;
    assign issue_dest  = r_issue_dest;
    assign inflight    = r_inflight;
    assign idle        = (r_inflight == 4'd0) && (r_pending == '0);
    assign err_commit  = r_err_commit;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Scoreboard bench for instr_issue_ctrl: a list-based model of in-flight writers predicts
// ready/count/error each cycle and queues expected issue strobes for a separate monitor.
module tb_instr_issue_ctrl;

    localparam int MAXI = 4;
    localparam int NB   = 4;
    localparam int BW   = 2;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready;
    logic [3:0]    src_a, src_b, src_c;
    logic          src_a_reg, src_b_reg, src_c_reg;
    logic          src_a_needed, src_b_needed, src_c_needed;
    logic [3:0]    dest;
    logic          commits;
    logic [BW-1:0] branch;
    logic [NB-1:0] branch_ready;
    logic [NB-1:0] issue_valid;
    logic [3:0]    issue_dest;
    logic          commit_valid;
    logic [3:0]    commit_dest;
    logic          flush;
    logic [3:0]    inflight;
    logic          idle, err_commit;

    always #5 clk = ~clk;

    instr_issue_ctrl #(.MAX_INFLIGHT(MAXI), .N_BRANCHES(NB)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .src_a(src_a), .src_b(src_b), .src_c(src_c),
        .src_a_reg(src_a_reg), .src_b_reg(src_b_reg), .src_c_reg(src_c_reg),
        .src_a_needed(src_a_needed), .src_b_needed(src_b_needed), .src_c_needed(src_c_needed),
        .dest(dest), .commits(commits), .branch(branch), .branch_ready(branch_ready),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .commit_valid(commit_valid), .commit_dest(commit_dest), .flush(flush),
        .inflight(inflight), .idle(idle), .err_commit(err_commit)
    );

    typedef struct {
        logic [NB-1:0] oh;
        logic [3:0]    dst;
        int            at;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    int   infl_q[$];     // destination registers of issued, uncommitted writers
    bit   m_err      = 1'b0;
    int   m_last_dst = 0;
    bit   m_valid    = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic bit is_pending(int r);
        foreach (infl_q[i]) if (infl_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic eval();
        bit rdy;
        bit iss;
        int idx;
        exp_t e;
        #1;
        rdy = 1'b0;
        if (!reset && !flush) begin
            rdy = branch_ready[branch];
            if (src_a_needed && src_a_reg && is_pending(src_a)) rdy = 1'b0;
            if (src_b_needed && src_b_reg && is_pending(src_b)) rdy = 1'b0;
            if (src_c_needed && src_c_reg && is_pending(src_c)) rdy = 1'b0;
            if (commits && is_pending(dest)) rdy = 1'b0;
            if (commits && infl_q.size() >= MAXI) rdy = 1'b0;
        end
        check("in_ready", int'(in_ready), int'(rdy));
        if (m_valid) begin
            check("inflight", int'(inflight), infl_q.size());
            check("idle", int'(idle), int'(infl_q.size() == 0));
            check("err_commit", int'(err_commit), int'(m_err));
            check("issue_dest_hold", int'(issue_dest), m_last_dst);
        end
        if (reset) begin
            infl_q.delete();
            m_err      = 1'b0;
            m_last_dst = 0;
            m_valid    = 1'b1;
        end else if (flush) begin
            infl_q.delete();
        end else begin
            iss = in_valid && rdy;
            if (commit_valid) begin
                idx = -1;
                foreach (infl_q[i]) if (infl_q[i] == int'(commit_dest)) idx = i;
                if (idx >= 0) infl_q.delete(idx);
                else m_err = 1'b1;
            end
            if (iss) begin
                if (commits) infl_q.push_back(int'(dest));
                e.oh  = NB'(1) << branch;
                e.dst = dest;
                e.at  = cyc + 1;
                exp_q.push_back(e);
                m_last_dst = int'(dest);
            end
        end
    endtask

    task automatic step();
        eval();
        @(negedge clk);
    endtask

    task automatic clr();
        reset = 0; flush = 0; in_valid = 0; commits = 0; commit_valid = 0;
        src_a = 0; src_b = 0; src_c = 0; dest = 0; commit_dest = 0; branch = 0;
        src_a_reg = 0; src_b_reg = 0; src_c_reg = 0;
        src_a_needed = 0; src_b_needed = 0; src_c_needed = 0;
        branch_ready = '1;
    endtask

    task automatic put(int d, int br, bit w);
        clr(); in_valid = 1; dest = 4'(d); branch = BW'(br); commits = w;
    endtask

    function automatic logic [3:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 5));
    endfunction

    // Monitor: every non-zero strobe must match the oldest expectation, including its cycle.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #2;
        if (issue_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", int'(issue_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("issue_valid", int'(issue_valid), int'(e.oh));
                check("issue_dest", int'(issue_dest), int'(e.dst));
                check("issue_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        clr();
        reset = 1;
        @(negedge clk);
        step(); step();
        clr();
        // RAW on r3: consumer waits for the commit, then issues one cycle later.
        put(3, 0, 1); step();
        put(7, 0, 0); src_a = 3; src_a_reg = 1; src_a_needed = 1; step(); step();
        commit_valid = 1; commit_dest = 3; step();
        commit_valid = 0; step();
        clr(); step();
        // Full: four writers, a fifth stalls, a non-writer still issues.
        for (int i = 1; i <= 4; i++) begin put(i, 1, 1); step(); end
        put(5, 1, 1); step(); step();
        commits = 0; step();
        for (int i = 1; i <= 4; i++) begin clr(); commit_valid = 1; commit_dest = 4'(i); step(); end
        // Simultaneous issue and commit leaves the count unchanged.
        put(1, 0, 1); step(); put(2, 0, 1); step();
        put(5, 3, 1); commit_valid = 1; commit_dest = 1; step();
        clr(); step();
        // Branch back-pressure.
        put(6, 2, 0); branch_ready = 4'b1011; step(); step();
        branch_ready = 4'b1111; step();
        clr(); step();
        // Spurious commit sets the sticky error; then flush with three in flight.
        reset = 1; step(); clr();
        commit_valid = 1; commit_dest = 9; step();
        clr(); step(); step();
        for (int i = 1; i <= 3; i++) begin put(i, 0, 1); step(); end
        put(8, 1, 1); flush = 1; step();
        clr(); step(); step();
        // Randomised traffic.
        repeat (4000) begin
            clr();
            reset        = ($urandom_range(0, 299) == 0);
            flush        = ($urandom_range(0, 59) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            src_a = pick_reg(); src_b = pick_reg(); src_c = pick_reg();
            src_a_reg    = 1'($urandom_range(0, 1));
            src_b_reg    = 1'($urandom_range(0, 1));
            src_c_reg    = 1'($urandom_range(0, 1));
            src_a_needed = 1'($urandom_range(0, 1));
            src_b_needed = 1'($urandom_range(0, 1));
            src_c_needed = 1'($urandom_range(0, 1));
            dest         = pick_reg();
            commits      = ($urandom_range(0, 3) != 0);
            branch       = BW'($urandom_range(0, NB - 1));
            for (int b = 0; b < NB; b++) branch_ready[b] = ($urandom_range(0, 4) != 0);
            if (infl_q.size() > 0) begin
                commit_valid = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 29) == 0) commit_dest = 4'($urandom_range(0, 15));
                else commit_dest = 4'(infl_q[$urandom_range(0, infl_q.size() - 1)]);
            end else begin
                commit_valid = ($urandom_range(0, 39) == 0);
                commit_dest  = 4'($urandom_range(0, 15));
            end
            step();
        end
        clr();
        repeat (3) step();
        check("pending_expectations", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_issue_ctrl.md
INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of issued, uncommitted register-writing instructions (range 1..15).
REQ-002 SHALL have parameter N_BRANCHES, default 4, meaning the number of execution branches (main, delay, LUT, mem).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  decoded instruction presented.
REQ-007 in_ready  out  1  instruction accepted this cycle (combinational).
REQ-008 src_a, src_b, src_c  in  4 each  source register addresses.
REQ-009 src_a_reg, src_b_reg, src_c_reg  in  1 each  the operand is a register-file operand.
REQ-010 src_a_needed, src_b_needed, src_c_needed  in  1 each  the operand is read by the operation.
REQ-011 dest  in  4  destination register.
REQ-012 commits  in  1  the instruction writes dest on completion.
REQ-013 branch  in  clog2(N_BRANCHES)  target execution branch.
REQ-014 branch_ready  in  N_BRANCHES  per-branch "can accept" signal.
REQ-015 issue_valid  out  N_BRANCHES  registered one-hot issue strobe.
REQ-016 issue_dest  out  4  registered dest of the issued instruction.
REQ-017 commit_valid, commit_dest  in  1, 4  writeback retires a register write.
REQ-018 flush  in  1  abandon all in-flight tracking.
REQ-019 inflight  out  4  current in-flight count.
REQ-020 idle  out  1  high when inflight is 0 and no register is pending.
REQ-021 err_commit  out  1  sticky flag: a commit arrived for a register that is not pending.

Function
REQ-022 SHALL hold a 16-bit pending scoreboard, one bit per register.
REQ-023 Source hazard X (X = a, b, c) SHALL be true when src_X_needed, src_X_reg and pending[src_X] are all 1.
REQ-024 WAW hazard SHALL be true when commits is 1 and pending[dest] is 1.
REQ-025 Full SHALL be true when commits is 1 and inflight == MAX_INFLIGHT.
REQ-026 in_ready SHALL equal !reset & !flush & branch_ready[branch] & no source hazard & no WAW hazard & !full.
REQ-027 Hazard checks SHALL use the registered scoreboard only, with no same-cycle commit bypass; an instruction blocked only by a commit in the same cycle issues one cycle later.
REQ-028 Issue SHALL be defined as in_valid & in_ready.
REQ-029 On issue, the next cycle SHALL have issue_valid = one-hot(branch) and issue_dest = dest; otherwise issue_valid SHALL be 0 and issue_dest SHALL hold its last value.
REQ-030 On issue with commits = 1, the block SHALL set pending[dest] and increment inflight.
REQ-031 On a commit with pending[commit_dest] = 1, the block SHALL clear pending[commit_dest] and decrement inflight.
REQ-032 On a commit with pending[commit_dest] = 0, the block SHALL leave the scoreboard and count unchanged and set err_commit.
REQ-033 A simultaneous issue (commits = 1) and valid commit SHALL apply both: set dest, clear commit_dest, and leave inflight unchanged.
REQ-034 Issue latency SHALL be 1 cycle from the accepting edge to issue_valid; there is no internal queue, and back-pressure is purely via in_ready.
REQ-035 On flush, the block SHALL clear pending and inflight, force issue_valid to 0 next cycle, ignore same-cycle issue and commit, and leave err_commit unchanged.
REQ-036 inflight SHALL never exceed MAX_INFLIGHT and never underflow.

Reset
REQ-037 On reset, pending SHALL be 0, inflight 0, issue_valid 0, issue_dest 0 and err_commit 0; idle SHALL be 1 and in_ready 0 during the reset cycle.
REQ-038 Reset mid-operation SHALL discard all in-flight tracking; commits arriving after reset for pre-reset registers SHALL set err_commit.
REQ-039 err_commit SHALL be cleared only by reset.

Verification
REQ-040 RAW: issue dest=3 to main, then present src_a=3 (needed, reg) -> in_ready=0 until commit_dest=3; issue occurs the cycle after the commit, with issue_valid=4'b0001.
REQ-041 Full: with MAX_INFLIGHT=4, issue 4 writers to dests 1..4 -> inflight=4 and a 5th writer is stalled; a non-committing instruction (commits=0) still issues.
REQ-042 Simultaneous: inflight=2, issue dest=5 while commit_dest=1 -> inflight stays 2, pending[5]=1, pending[1]=0.
REQ-043 Branch back-pressure: branch=2 with branch_ready=4'b1011 -> no issue; raising bit 2 -> issue_valid=4'b0100 one cycle later.
REQ-044 Spurious commit: commit_dest=9 while pending=0 -> err_commit=1 and stays 1 until reset; inflight stays 0.
REQ-045 Flush: 3 in flight, assert flush together with in_valid -> no issue_valid; next cycle inflight=0 and idle=1.
